mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/mem_access_unit.sv | 179 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: definitions shared by the memory access unit and its lane aligner.
//   size_e     - access size codes as they appear on req_size.
//   state_e    - controller states.
//   req_error  - decides whether a request is rejected without touching memory.
//   word_addr  - word-aligned form of a byte address.
package mem_access_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2,
    RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2,
    RESP   = 2'd3
  } state_e;

  // The range test is conservative: it uses addr + 3 for every size, so the
  // last three bytes of memory are never reachable, even by byte accesses.
  // The sum is formed in 33 bits so that addresses near 2^32 cannot wrap
  // back into range.
  function automatic logic req_error(input size_e size, input logic [31:0] addr,
                                     input int unsigned mem_bytes);
    logic [32:0] last_byte;
    last_byte = {1'b0, addr} + 33'd3;
    req_error = (size == RSVD)
             || (size == HALF && addr[0])
             || (size == WORD && addr[1:0] != 2'b00)
             || (last_byte >= 33'(mem_bytes));
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    word_addr = {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: purely combinational lane handling for big-endian memory.
//   word_in     in  32  word read from memory
//   offset      in  2   byte offset of the access inside the word
//   size        in  2   access size (size_e)
//   sign_ext    in  1   sign-extend sub-word loads
//   store_data  in  32  right-justified store data
//   load_data   out 32  addressed lane, extended to 32 bits
//   merged_word out 32  word_in with the addressed lane replaced by store_data
// Byte offset k lives in bits [31-8k -: 8]; half offset 0 is [31:16] and
// half offset 2 is [15:0].
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  lane [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = word_in[31-8*gi -: 8];
    end
  endgenerate

  always_comb begin
    sel_byte    = lane[offset];
    sel_half    = offset[1] ? {lane[2], lane[3]} : {lane[0], lane[1]};
    load_data   = word_in;
    merged_word = word_in;
    case (size)
      BYTE: begin
        load_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
        case (offset)
          2'd0:    merged_word[31:24] = store_data[7:0];
          2'd1:    merged_word[23:16] = store_data[7:0];
          2'd2:    merged_word[15:8]  = store_data[7:0];
          default: merged_word[7:0]   = store_data[7:0];
        endcase
      end
      HALF: begin
        load_data = {{16{sign_ext & sel_half[15]}}, sel_half};
        if (offset[1]) merged_word[15:0]  = store_data[15:0];
        else           merged_word[31:16] = store_data[15:0];
      end
      // A full-word store replaces the whole word.
      WORD:    merged_word = store_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between a pipeline and a word-wide data
// memory with a combinational read port and a clock-edge write port.
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only when idle)
//   req_write, req_size, req_signed, req_addr, req_wdata   request fields
//   resp_valid, resp_rdata, resp_err                       one-cycle response
//   mem_address, mem_writeData, mem_memwrite, mem_memread, mem_out32
//                            data memory port
// Sub-word stores are done as read-modify-write: the word is read in ACCESS,
// the lane is merged, and the merged word is written in RMW_WR.
// All outputs are registered so that reset clears them immediately.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_out32
);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  size_e       size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        mem_memread_q, mem_memread_d;
  logic        mem_memwrite_q, mem_memwrite_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_writeData_q, mem_writeData_d;

  logic [31:0] load_data;
  logic [31:0] merged_word;

  mem_lane_align u_align (
    .word_in     (mem_out32),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .sign_ext    (sign_q),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d         = state_q;
    write_d         = write_q;
    size_d          = size_q;
    sign_d          = sign_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    req_ready_d     = 1'b0;
    resp_valid_d    = 1'b0;
    resp_err_d      = 1'b0;
    resp_rdata_d    = '0;
    mem_memread_d   = 1'b0;
    mem_memwrite_d  = 1'b0;
    mem_address_d   = '0;
    mem_writeData_d = '0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          write_d     = req_write;
          size_d      = size_e'(req_size);
          sign_d      = req_signed;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (req_error(size_e'(req_size), req_addr, MEM_BYTES)) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            // Memory strobes for ACCESS are set up here so they are
            // registered outputs during that state.
            state_d       = ACCESS;
            mem_address_d = word_addr(req_addr);
            if (req_write && size_e'(req_size) == WORD) begin
              mem_memwrite_d  = 1'b1;
              mem_writeData_d = req_wdata;
            end else begin
              mem_memread_d = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        if (write_q && size_q == WORD) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else if (!write_q) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end else begin
          // Capture the merged word now; mem_out32 is only valid this cycle.
          state_d         = RMW_WR;
          mem_memwrite_d  = 1'b1;
          mem_address_d   = word_addr(addr_q);
          mem_writeData_d = merged_word;
        end
      end
      RMW_WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      write_q         <= 1'b0;
      size_q          <= BYTE;
      sign_q          <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= '0;
      mem_memread_q   <= 1'b0;
      mem_memwrite_q  <= 1'b0;
      mem_address_q   <= '0;
      mem_writeData_q <= '0;
    end else begin
      state_q         <= state_d;
      write_q         <= write_d;
      size_q          <= size_d;
      sign_q          <= sign_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_err_q      <= resp_err_d;
      resp_rdata_q    <= resp_rdata_d;
      mem_memread_q   <= mem_memread_d;
      mem_memwrite_q  <= mem_memwrite_d;
      mem_address_q   <= mem_address_d;
      mem_writeData_q <= mem_writeData_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_memread   = mem_memread_q;
  assign mem_memwrite  = mem_memwrite_q;
  assign mem_address   = mem_address_q;
  assign mem_writeData = mem_writeData_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a byte-array reference memory predicts every
// response and memory-port cycle; a compare process checks the DUT each
// cycle, and directed transactions also check literal expected values.
module tb_mem_access_unit;

  localparam int unsigned MEM_BYTES = 256;
  localparam int NWORDS = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_writeData, mem_out32;
  logic        mem_memwrite, mem_memread;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_out32(mem_out32)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Attached data memory (word array, combinational read, edge write)
  logic [31:0] mem [NWORDS];
  int          wr_count = 0;
  int          rd_count = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  assign mem_out32 = mem[mem_address[$clog2(MEM_BYTES)-1:2]];

  always @(posedge clk) begin
    if (mem_memwrite) begin
      mem[mem_address[$clog2(MEM_BYTES)-1:2]] <= mem_writeData;
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_address;
      last_wr_data <= mem_writeData;
    end
    if (mem_memread) rd_count <= rd_count + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: byte-addressed big-endian memory
  logic [7:0] ref_mem [MEM_BYTES];
  int exp_writes = 0;

  typedef struct {
    int          due;     // cycle in which resp_valid must be seen
    logic        err;
    logic [31:0] rdata;
    int          rd_cyc;  // cycle with mem_memread expected, -1 if none
    int          wr_cyc;  // cycle with mem_memwrite expected, -1 if none
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] ref_word(input int i);
    return {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
  endfunction

  function automatic logic [31:0] ref_load(input int i, input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = ref_mem[i];
    h = {ref_mem[i], ref_mem[i+1]};
    if (sz == 2'd0) return sg ? {{24{b[7]}}, b} : {24'h0, b};
    if (sz == 2'd1) return sg ? {{16{h[15]}}, h} : {16'h0, h};
    return ref_word(i);
  endfunction

  logic model_on = 1'b1;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          last_resp_cyc = 0;

  // Per-cycle compare against the model
  always @(posedge clk) begin : cmp
    exp_t f;
    logic has, e_rd, e_wr, e_v;
    #2;
    if (model_on) begin
      has = (exp_q.size() != 0);
      if (has) f = exp_q[0];
      e_rd = has && f.rd_cyc == cyc;
      e_wr = has && f.wr_cyc == cyc;
      e_v  = has && f.due == cyc;
      check("req_ready", {31'h0, req_ready}, {31'h0, !has});
      check("mem_memread", {31'h0, mem_memread}, {31'h0, e_rd});
      check("mem_memwrite", {31'h0, mem_memwrite}, {31'h0, e_wr});
      check("mem_address", mem_address, (e_rd || e_wr) ? f.waddr : 32'h0);
      if (e_wr) check("mem_writeData", mem_writeData, f.wdata);
      check("resp_valid", {31'h0, resp_valid}, {31'h0, e_v});
      if (e_v && resp_valid) begin
        check("resp_err", {31'h0, resp_err}, {31'h0, f.err});
        check("resp_rdata", resp_rdata, f.rdata);
      end
      if (resp_valid) begin
        last_rdata    = resp_rdata;
        last_err      = resp_err;
        last_resp_cyc = cyc;
        $display("resp cyc=%0d err=%0b rdata=0x%08h", cyc, resp_err, resp_rdata);
      end
      if (e_v) void'(exp_q.pop_front());
    end
  end

  // Drive a request at a negedge and wait (bounded) for acceptance.
  // Returns at the negedge following the accept edge with req_valid still high.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output int acc);
    exp_t e;
    int   n;
    int   i;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", {31'h0, req_ready}, 32'h1);
    acc = cyc + 1;
    i = int'(a[7:0]);
    e.err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
         || (longint'(a) + 3 >= longint'(MEM_BYTES));
    e.rd_cyc = -1; e.wr_cyc = -1; e.rdata = '0; e.wdata = '0;
    e.waddr = {a[31:2], 2'b00};
    if (e.err) begin
      e.due = acc;
    end else if (!w) begin
      e.rd_cyc = acc; e.due = acc + 1;
      e.rdata = ref_load(i, sz, sg);
    end else begin
      if (sz == 2'd0) ref_mem[i] = wd[7:0];
      else if (sz == 2'd1) begin ref_mem[i] = wd[15:8]; ref_mem[i+1] = wd[7:0]; end
      else begin
        ref_mem[i] = wd[31:24]; ref_mem[i+1] = wd[23:16];
        ref_mem[i+2] = wd[15:8]; ref_mem[i+3] = wd[7:0];
      end
      e.wdata = ref_word(int'(e.waddr[7:0]));
      exp_writes++;
      if (sz == 2'd2) begin e.wr_cyc = acc; e.due = acc + 1; end
      else begin e.rd_cyc = acc; e.wr_cyc = acc + 1; e.due = acc + 2; end
    end
    exp_q.push_back(e);
    $display("req cyc=%0d w=%0b size=%0d signed=%0b addr=0x%08h wdata=0x%08h",
             acc, w, sz, sg, a, wd);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
  endtask

  task automatic do_load(input string nm, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] lit);
    int acc, w0;
    w0 = wr_count;
    issue(1'b0, sz, sg, a, 32'h0, acc);
    req_valid = 1'b0;
    drain();
    check({nm, "_rdata"}, last_rdata, lit);
    check({nm, "_latency"}, 32'(last_resp_cyc - acc + 1), 32'd2);
    check({nm, "_nowrite"}, 32'(wr_count - w0), 32'd0);
  endtask

  task automatic do_err(input string nm, input logic w, input logic [1:0] sz, input logic [31:0] a);
    int acc, w0, r0;
    w0 = wr_count; r0 = rd_count;
    issue(w, sz, 1'b0, a, 32'h5A5A5A5A, acc);
    req_valid = 1'b0;
    drain();
    check({nm, "_err"}, {31'h0, last_err}, 32'h1);
    check({nm, "_rdata"}, last_rdata, 32'h0);
    check({nm, "_latency"}, 32'(last_resp_cyc - acc + 1), 32'd1);
    check({nm, "_nomem"}, 32'((wr_count - w0) + (rd_count - r0)), 32'd0);
  endtask

  initial begin : main
    int acc, acc2, w0, seen;
    for (int k = 0; k < NWORDS; k++) mem[k] <= 32'h0;
    mem[0] <= 32'h00430822;
    mem[1] <= 32'h8CA40006;
    for (int k = 0; k < int'(MEM_BYTES); k++) ref_mem[k] = 8'h00;
    {ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]} = 32'h00430822;
    {ref_mem[4], ref_mem[5], ref_mem[6], ref_mem[7]} = 32'h8CA40006;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_mem_strobes", {30'h0, mem_memread, mem_memwrite}, 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    do_load("lw4", 2'd2, 1'b0, 32'd4, 32'h8CA40006);
    do_load("lb4", 2'd0, 1'b1, 32'd4, 32'hFFFFFF8C);
    do_load("lbu4", 2'd0, 1'b0, 32'd4, 32'h0000008C);
    do_load("lh6", 2'd1, 1'b1, 32'd6, 32'h00000006);
    do_load("lh4", 2'd1, 1'b1, 32'd4, 32'hFFFF8CA4);
    do_load("lhu4", 2'd1, 1'b0, 32'd4, 32'h00008CA4);
    do_load("lbu7", 2'd0, 1'b0, 32'd7, 32'h00000006);

    // Byte store via read-modify-write
    w0 = wr_count;
    issue(1'b1, 2'd0, 1'b0, 32'd1, 32'h000000AB, acc);
    req_valid = 1'b0;
    drain();
    check("sb1_writes", 32'(wr_count - w0), 32'd1);
    check("sb1_wr_addr", last_wr_addr, 32'h0);
    check("sb1_wr_data", last_wr_data, 32'h00AB0822);
    check("sb1_latency", 32'(last_resp_cyc - acc + 1), 32'd3);
    check("sb1_rdata", last_rdata, 32'h0);
    do_load("lw0_after_sb", 2'd2, 1'b0, 32'd0, 32'h00AB0822);

    // Word store and half store to a fresh word
    issue(1'b1, 2'd2, 1'b0, 32'd8, 32'h12345678, acc);
    req_valid = 1'b0;
    drain();
    check("sw8_latency", 32'(last_resp_cyc - acc + 1), 32'd2);
    check("sw8_wr_data", last_wr_data, 32'h12345678);
    issue(1'b1, 2'd1, 1'b0, 32'd10, 32'hFFFFCAFE, acc);
    req_valid = 1'b0;
    drain();
    do_load("lw8_after_sh", 2'd2, 1'b0, 32'd8, 32'h1234CAFE);

    // Error cases
    do_err("lw2", 1'b0, 2'd2, 32'd2);
    do_err("sh3", 1'b1, 2'd1, 32'd3);
    do_err("lw_top", 1'b0, 2'd2, MEM_BYTES - 2);
    do_err("rsvd", 1'b0, 2'd3, 32'd0);
    do_err("lb_253", 1'b0, 2'd0, 32'd253);

    // Reset during RMW_WR of sh 0xBEEF to address 2
    model_on = 1'b0;
    w0 = wr_count;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'd2; req_wdata = 32'h0000BEEF;
    @(posedge clk);           // accept
    @(negedge clk);
    req_valid = 1'b0;         // ACCESS
    @(posedge clk);           // enter RMW_WR
    #1;
    check("rmw_before_rst", {31'h0, mem_memwrite}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_drops_memwrite", {31'h0, mem_memwrite}, 32'h0);
    check("rst_ready_async", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("rst_no_resp", 32'(seen), 32'd0);
    check("rst_no_write", 32'(wr_count - w0), 32'd0);
    check("rst_word0", mem[0], 32'h00AB0822);
    check("rst_ready_after", {31'h0, req_ready}, 32'h1);
    model_on = 1'b1;
    @(negedge clk);

    // Back-to-back loads with req_valid held high
    issue(1'b0, 2'd2, 1'b0, 32'd0, 32'h0, acc);
    issue(1'b0, 2'd2, 1'b0, 32'd4, 32'h0, acc2);
    req_valid = 1'b0;
    drain();
    check("b2b_spacing", 32'(acc2 - acc), 32'd3);
    check("b2b_rdata", last_rdata, 32'h8CA40006);

    check("total_writes", 32'(wr_count), 32'(exp_writes));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
